// File: rtl/core_pkg.sv
// Shared decode-stage definitions: datapath widths, immediate format codes
// and the occupancy states of the ID skid buffer.
package core_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Format code is taken straight from instr[6:5]
    localparam logic [1:0] FMT_I    = 2'b00;
    localparam logic [1:0] FMT_S    = 2'b01;
    localparam logic [1:0] FMT_B    = 2'b11;
    localparam logic [1:0] FMT_NONE = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/id_stage_ctrl_imm_gen.sv
// imm_gen: combinational instruction -> sign-extended immediate and format code.
// Sits on the capture path so the buffered entries already hold their immediate.
module imm_gen #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [1:0]      fmt_o
);
    import core_pkg::*;

    logic [11:0] imm12;

    // Bits that no immediate format draws from
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[19:12], instr_i[4:0]};

    // Select the 12-bit immediate field by format; B-type stays in halfword units
    always_comb begin
        imm12 = '0;
        fmt_o = instr_i[6:5];
        case (instr_i[6:5])
            FMT_I:    imm12 = instr_i[31:20];
            FMT_S:    imm12 = {instr_i[31:25], instr_i[11:7]};
            FMT_B:    imm12 = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
            FMT_NONE: imm12 = '0;
        endcase
    end

    assign imm_o = {{(XLEN-12){imm12[11]}}, imm12};

endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode-stage 2-entry skid buffer between IF and EX.
// Handshakes: a transfer happens on a cycle where valid && ready are both high;
// if_ready and id_valid are decoded from registered occupancy only, and the
// head payload holds steady while id_valid && !ex_ready.
// Optional stall counter enabled with macro ID_PERF_CNT_EN.
module id_stage_ctrl #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [ILEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            ex_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_imm,
    output logic [1:0]      id_fmt,
    output logic [31:0]     perf_stall_cnt,
    output logic [1:0]      dbg_state
);
    import core_pkg::*;

    occ_state_e state_q, state_d;

    // Head entry drives EX; skid entry holds the second instruction
    logic [ILEN-1:0] hd_instr_q, sk_instr_q;
    logic [XLEN-1:0] hd_pc_q,    sk_pc_q;
    logic [XLEN-1:0] hd_imm_q,   sk_imm_q;
    logic [1:0]      hd_fmt_q,   sk_fmt_q;

    logic [XLEN-1:0] cap_imm;
    logic [1:0]      cap_fmt;

    logic push, pop;
    logic ld_head_in, ld_head_sk, ld_sk;

    imm_gen #(.XLEN(XLEN), .ILEN(ILEN)) u_imm_gen (
        .instr_i (if_instr),
        .imm_o   (cap_imm),
        .fmt_o   (cap_fmt)
    );

    assign if_ready  = (state_q != TWO);
    assign id_valid  = (state_q != EMPTY);
    assign dbg_state = state_q;

    assign push = if_valid && if_ready && !flush;
    assign pop  = id_valid && ex_ready;

    assign id_instr = hd_instr_q;
    assign id_pc    = hd_pc_q;
    assign id_imm   = hd_imm_q;
    assign id_fmt   = hd_fmt_q;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and which payload slots load this cycle
    always_comb begin
        state_d    = state_q;
        ld_head_in = 1'b0;
        ld_head_sk = 1'b0;
        ld_sk      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d    = ONE;
                    ld_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ld_head_in = 1'b1;
                end else if (push) begin
                    state_d = TWO;
                    ld_sk   = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d    = ONE;
                    ld_head_sk = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush empties the buffer; push is already masked so nothing new lands
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // Payload registers: head loads from fetch or from the skid slot
    always_ff @(posedge clk) begin
        if (reset) begin
            hd_instr_q <= '0;
            hd_pc_q    <= '0;
            hd_imm_q   <= '0;
            hd_fmt_q   <= '0;
            sk_instr_q <= '0;
            sk_pc_q    <= '0;
            sk_imm_q   <= '0;
            sk_fmt_q   <= '0;
        end else begin
            if (ld_head_in) begin
                hd_instr_q <= if_instr;
                hd_pc_q    <= if_pc;
                hd_imm_q   <= cap_imm;
                hd_fmt_q   <= cap_fmt;
            end else if (ld_head_sk) begin
                hd_instr_q <= sk_instr_q;
                hd_pc_q    <= sk_pc_q;
                hd_imm_q   <= sk_imm_q;
                hd_fmt_q   <= sk_fmt_q;
            end
            if (ld_sk) begin
                sk_instr_q <= if_instr;
                sk_pc_q    <= if_pc;
                sk_imm_q   <= cap_imm;
                sk_fmt_q   <= cap_fmt;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles where EX holds off a valid head; wraps naturally, ignores flush
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (id_valid && !ex_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Testbench for id_stage_ctrl: directed vectors followed by random traffic,
// checked by a queue-based FIFO reference model and scoreboard monitor.
module tb_id_stage_ctrl;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [1:0]  fmt;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instr = '0;
    logic [63:0] if_pc = '0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        ex_ready = 1'b0;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic [63:0] id_imm;
    logic [1:0]  id_fmt;
    logic [31:0] perf_stall_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    id_stage_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .flush          (flush),
        .id_valid       (id_valid),
        .ex_ready       (ex_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_imm         (id_imm),
        .id_fmt         (id_fmt),
        .perf_stall_cnt (perf_stall_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- reference model state ----------------
    exp_t        exp_q[$];
    int          model_cnt = 0;
    logic [31:0] exp_stall = '0;
    int          n_checks = 0;
    int          n_err = 0;

`ifdef ID_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Immediate from the instruction's field rules, using integer arithmetic
    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        int v;
        case (ins[6:5])
            2'b00:   v = int'(ins[31:20]);
            2'b01:   v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
            2'b11:   v = int'(ins[31]) * 2048 + int'(ins[7]) * 1024
                         + int'(ins[30:25]) * 16 + int'(ins[11:8]);
            default: v = 0;
        endcase
        if (v >= 2048) v = v - 4096;
        return longint'(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit rst, input bit v, input logic [31:0] ins,
                               input logic [63:0] pc, input bit fl, input bit er);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        flush    = fl;
        ex_ready = er;
        model_cnt = exp_q.size();
        if (!rst && !fl && v && model_cnt < 2) begin
            e.instr = ins;
            e.pc    = pc;
            e.imm   = ref_imm(ins);
            e.fmt   = ins[6:5];
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input bit er);
        drive_cycle(1'b0, 1'b0, $urandom, {$urandom, $urandom}, 1'b0, er);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t h;
        bit   stall;
        forever begin
            @(negedge clk);
            check("if_ready", 64'(if_ready), 64'(model_cnt < 2));
            check("id_valid", 64'(id_valid), 64'(model_cnt > 0));
            if (model_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    check("head_avail", 64'(exp_q.size()), 64'd1);
                end else begin
                    h = exp_q[0];
                    check("id_instr", 64'(id_instr), 64'(h.instr));
                    check("id_pc", id_pc, h.pc);
                    check("id_imm", id_imm, h.imm);
                    check("id_fmt", 64'(id_fmt), 64'(h.fmt));
                end
            end
            check("perf_cnt", 64'(perf_stall_cnt), PERF_ON ? 64'(exp_stall) : 64'd0);
            stall = (model_cnt > 0) && !ex_ready;
            if (model_cnt > 0 && ex_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (reset) exp_stall = '0;
            else if (stall) exp_stall = exp_stall + 32'd1;
            if (reset || flush) exp_q.delete();
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed then random stimulus ----------------
    initial begin
        // reset state
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("rst_instr", 64'(id_instr), 64'd0);
        check("rst_pc", id_pc, 64'd0);
        check("rst_imm", id_imm, 64'd0);
        check("rst_fmt", 64'(id_fmt), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(EMPTY));
        check("rst_ready", 64'(if_ready), 64'd1);

        // I-type
        drive_cycle(1'b0, 1'b1, 32'hFFF00093, 64'h1000, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        check("i_valid", 64'(id_valid), 64'd1);
        check("i_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("i_fmt", 64'(id_fmt), 64'd0);

        // S-type
        drive_cycle(1'b0, 1'b1, 32'h00B13423, 64'h1004, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        check("s_imm", id_imm, 64'h0000_0000_0000_0008);
        check("s_fmt", 64'(id_fmt), 64'd1);

        // B-type
        drive_cycle(1'b0, 1'b1, 32'hFE000EE3, 64'h1008, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        check("b_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b_fmt", 64'(id_fmt), 64'd3);
        idle(1'b1);

        // back-pressure
        drive_cycle(1'b0, 1'b1, 32'h00000013, 64'h100, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h00100013, 64'h104, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("bp_ready_full", 64'(if_ready), 64'd0);
        check("bp_pc_hold", id_pc, 64'h100);
        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        check("bp_pc_next", id_pc, 64'h104);
        check("bp_ready_free", 64'(if_ready), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // flush with a full buffer and an incoming instruction
        drive_cycle(1'b0, 1'b1, 32'h00200013, 64'h1F0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h00300013, 64'h1F4, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h00400013, 64'h200, 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk);
        check("fl_valid", 64'(id_valid), 64'd0);
        check("fl_state", 64'(dbg_state), 64'(EMPTY));
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            @(negedge clk);
            check("fl_no_200", 64'(id_valid && id_pc == 64'h200), 64'd0);
        end

        // stall counter: 5 stall cycles, then reset mid-stall
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h00500013, 64'h300, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        check("perf_5", 64'(perf_stall_cnt), PERF_ON ? 64'd5 : 64'd0);
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("perf_rst", 64'(perf_stall_cnt), 64'd0);
        check("perf_rst_valid", 64'(id_valid), 64'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 199) == 0,
                        $urandom_range(0, 9) < 7,
                        $urandom,
                        {$urandom, $urandom},
                        $urandom_range(0, 15) == 0,
                        $urandom_range(0, 9) < 6);
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
